// File: rtl/scan_id_sync_array.sv
// Multi-channel scan-ID synchroniser with stability filter, edge qualifier,
// sticky pending flags and saturating event counters.
module scan_id_sync_array #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 0,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       scan_id,
    input  logic [1:0]           edge_mode,
    input  logic [NCH-1:0]       pend_clr,
    input  logic                 cnt_clr,
    output logic [NCH-1:0]       id_valid,
    output logic [NCH-1:0]       id_level,
    output logic [NCH-1:0]       pend,
    output logic [NCH*CNT_W-1:0] evt_cnt
);

    localparam int FW = (FILT_CYC > 0) ? $clog2(FILT_CYC + 1) : 1;
    localparam logic [FW-1:0] FMAX = FW'(FILT_CYC);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [SYNC_STAGES-1:0] r_sync [NCH];
    logic [FW-1:0]          r_fcnt [NCH];
    logic [CNT_W-1:0]       r_cnt  [NCH];
    logic [NCH-1:0]         r_level;
    logic [NCH-1:0]         r_pend;
    logic [NCH-1:0]         w_s;
    logic [NCH-1:0]         w_acc;

    // A change is accepted once it has differed from the level for FILT_CYC+1 cycles
    always_comb begin
        w_s      = '0;
        w_acc    = '0;
        id_valid = '0;
        evt_cnt  = '0;
        for (int i = 0; i < NCH; i++) begin
            w_s[i]      = r_sync[i][SYNC_STAGES-1];
            w_acc[i]    = (w_s[i] != r_level[i]) && (r_fcnt[i] == FMAX);
            id_valid[i] = w_acc[i] & (w_s[i] ? edge_mode[0] : edge_mode[1]);
            evt_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign id_level = r_level;
    assign pend     = r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_sync[i] <= '0;
                r_fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], scan_id[i]};
                if (w_s[i] == r_level[i] || w_acc[i]) begin
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_pend  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_acc[i]) begin
                    r_level[i] <= w_s[i];
                end
                if (id_valid[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (pend_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // A clear coinciding with an event leaves a count of one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cnt_clr) begin
                    r_cnt[i] <= CNT_W'(id_valid[i]);
                end else if (id_valid[i] && r_cnt[i] != CMAX) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_id_sync_array.sv
// Bench for scan_id_sync_array: an unfiltered narrow-counter instance and a
// filtered instance share stimulus and are checked against a window model.
module tb_scan_id_sync_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  scan_id = '0;
    logic [1:0]  edge_mode = 2'b11;
    logic [3:0]  pend_clr = '0;
    logic        cnt_clr = 1'b0;

    logic [3:0]  a_valid, a_level, a_pend;
    logic [7:0]  a_cnt;
    logic [3:0]  b_valid, b_level, b_pend;
    logic [31:0] b_cnt;

    int total = 0;
    int bad = 0;
    int pa[4] = '{0, 0, 0, 0};
    int pb[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    scan_id_sync_array #(
        .NCH(4), .SYNC_STAGES(2), .FILT_CYC(0), .CNT_W(2)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .scan_id(scan_id),
        .edge_mode(edge_mode), .pend_clr(pend_clr), .cnt_clr(cnt_clr),
        .id_valid(a_valid), .id_level(a_level), .pend(a_pend),
        .evt_cnt(a_cnt)
    );

    scan_id_sync_array #(
        .NCH(4), .SYNC_STAGES(2), .FILT_CYC(3), .CNT_W(8)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .scan_id(scan_id),
        .edge_mode(edge_mode), .pend_clr(pend_clr), .cnt_clr(cnt_clr),
        .id_valid(b_valid), .id_level(b_level), .pend(b_pend),
        .evt_cnt(b_cnt)
    );

    // Model: history of sampled scan_id; s is the sample from two edges ago
    logic [3:0] samp[$];
    logic [3:0] m_level[2];
    logic [3:0] m_pend[2];
    int         m_cnt[2][4];

    function automatic int filt(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic logic s_at(int j, int c);
        logic [3:0] v;
        v = samp[samp.size() - 2 - j];
        return v[c];
    endfunction

    function automatic logic acc(int k, int c);
        logic v;
        v = s_at(0, c);
        if (v == m_level[k][c]) return 1'b0;
        for (int j = 1; j <= filt(k); j++)
            if (s_at(j, c) != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic qual(int k, int c);
        return acc(k, c) && (s_at(0, c) ? edge_mode[0] : edge_mode[1]);
    endfunction

    task automatic mreset();
        samp.delete();
        repeat (5) samp.push_back(4'h0);
        for (int k = 0; k < 2; k++) begin
            m_level[k] = '0;
            m_pend[k] = '0;
            for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    logic a, q;
                    a = acc(k, c);
                    q = qual(k, c);
                    if (cnt_clr) m_cnt[k][c] = q ? 1 : 0;
                    else if (q && m_cnt[k][c] < cmax(k)) m_cnt[k][c]++;
                    if (q) m_pend[k][c] = 1'b1;
                    else if (pend_clr[c]) m_pend[k][c] = 1'b0;
                    if (a) m_level[k][c] = s_at(0, c);
                end
            end
            samp.push_back(scan_id);
            void'(samp.pop_front());
        end
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0]  ev[2];
        logic [31:0] ec[2];
        for (int k = 0; k < 2; k++) begin
            ev[k] = '0;
            ec[k] = '0;
            for (int c = 0; c < 4; c++) begin
                ev[k][c] = qual(k, c);
                ec[k] = ec[k] | (32'(m_cnt[k][c]) << (k == 0 ? 2 * c : 8 * c));
            end
        end
        chk("a_valid", 32'(a_valid), 32'(ev[0]));
        chk("a_level", 32'(a_level), 32'(m_level[0]));
        chk("a_pend", 32'(a_pend), 32'(m_pend[0]));
        chk("a_cnt", 32'(a_cnt), ec[0]);
        chk("b_valid", 32'(b_valid), 32'(ev[1]));
        chk("b_level", 32'(b_level), 32'(m_level[1]));
        chk("b_pend", 32'(b_pend), 32'(m_pend[1]));
        chk("b_cnt", b_cnt, ec[1]);
        for (int c = 0; c < 4; c++) begin
            if (a_valid[c] === 1'b1) pa[c]++;
            if (b_valid[c] === 1'b1) pb[c]++;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic all_zero(string n);
        chk({n, "_av"}, 32'(a_valid), 0);
        chk({n, "_al"}, 32'(a_level), 0);
        chk({n, "_ap"}, 32'(a_pend), 0);
        chk({n, "_ac"}, 32'(a_cnt), 0);
        chk({n, "_bv"}, 32'(b_valid), 0);
        chk({n, "_bc"}, b_cnt, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cyc(3);
        @(negedge clk);
        all_zero("reset");
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // channel 0 rise and fall, both edges reported
        scan_id[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s1_rise_early", 32'(a_valid[0]), 0);
        @(posedge clk);
        @(negedge clk);
        chk("s1_rise_lat", 32'(a_valid[0]), 1);
        cyc(9);
        scan_id[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("s1_fall_lat", 32'(a_valid[0]), 1);
        cyc(9);
        chk("s1_cnt0", 32'(a_cnt[1:0]), 2);
        chk("s1_pend", 32'(a_pend), 32'h1);
        chk("s1_pulses", 32'(pa[0]), 2);
        chk("s1_others", 32'(a_cnt[7:2]), 0);
        chk("s1_b_cnt", b_cnt, 32'h2);

        // channel 1 glitch then real pulse
        scan_id[1] = 1'b1;
        cyc(2);
        scan_id[1] = 1'b0;
        cyc(6);
        scan_id[1] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("s2_b_early", 32'(b_valid[1]), 0);
        @(posedge clk);
        @(negedge clk);
        chk("s2_b_lat", 32'(b_valid[1]), 1);
        cyc(1);
        scan_id[1] = 1'b0;
        cyc(8);
        chk("s2_b_pulses", 32'(pb[1]), 2);
        chk("s2_a_pulses", 32'(pa[1]), 4);
        chk("s2_a_sat", 32'(a_cnt[3:2]), 3);
        chk("s2_b_cnt1", 32'(b_cnt[15:8]), 2);

        // rising-only mode on channel 3
        edge_mode = 2'b01;
        scan_id[3] = 1'b1;
        cyc(8);
        scan_id[3] = 1'b0;
        cyc(8);
        chk("s3_a_lvl_lo", 32'(a_level[3]), 0);
        chk("s3_b_lvl_lo", 32'(b_level[3]), 0);
        scan_id[3] = 1'b1;
        cyc(8);
        chk("s3_a_pulses", 32'(pa[3]), 2);
        chk("s3_b_pulses", 32'(pb[3]), 2);
        chk("s3_a_cnt3", 32'(a_cnt[7:6]), 2);
        chk("s3_a_lvl_hi", 32'(a_level[3]), 1);
        edge_mode = 2'b11;

        // saturation then counter clear colliding with an event
        for (int i = 0; i < 5; i++) begin
            scan_id[2] = ~scan_id[2];
            cyc(6);
        end
        chk("s4_a_sat", 32'(a_cnt[5:4]), 3);
        chk("s4_b_cnt2", 32'(b_cnt[23:16]), 5);
        scan_id[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 cnt_clr = 1'b1;
        @(posedge clk);
        #2 cnt_clr = 1'b0;
        cyc(6);
        chk("s4_a_clr", 32'(a_cnt), 32'h10);
        chk("s4_b_clr", b_cnt, 32'h0001_0000);

        // pend clear colliding with an event, then alone
        pend_clr = 4'b0100;
        cyc(1);
        pend_clr = '0;
        scan_id[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 pend_clr[2] = 1'b1;
        @(posedge clk);
        #2 pend_clr[2] = 1'b0;
        @(negedge clk);
        chk("s5_set_wins", 32'(a_pend[2]), 1);
        cyc(6);
        pend_clr[2] = 1'b1;
        cyc(1);
        pend_clr[2] = 1'b0;
        @(negedge clk);
        chk("s5_a_clr", 32'(a_pend[2]), 0);
        chk("s5_b_clr", 32'(b_pend[2]), 0);

        // reset mid-filter with all lines high
        scan_id = 4'hF;
        cyc(2);
        rst_n = 1'b0;
        @(negedge clk);
        all_zero("rst_mid");
        cyc(2);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("s6_a_lat", 32'(a_valid), 32'hF);
        chk("s6_b_quiet", 32'(b_valid), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s6_b_lat", 32'(b_valid), 32'hF);
        cyc(4);
        chk("s6_a_lvl", 32'(a_level), 32'hF);
        chk("s6_b_lvl", 32'(b_level), 32'hF);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
